mem_port_arbiter: RTL

Arbitrates the single shared data-memory port (DPI-backed load/store memory) between the instruction-fetch requester (port IF) and the load/store requester (port LS). It serialises requests with one transaction outstanding, checks size/alignment before issue, sequences the memory-side request/response handshake, and returns a per-port response with an error flag. It sits between the core front end / memory stage and the memory model.

---
 rtl/mem_port_arbiter_pkg.sv | 30 +++
 rtl/mem_port_arbiter_rr_arb2.sv | 42 ++++
 rtl/mem_port_arbiter.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and encodings for the shared memory-port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } arb_state_t;

  localparam logic [1:0] LEN_B = 2'b00;
  localparam logic [1:0] LEN_H = 2'b01;
  localparam logic [1:0] LEN_W = 2'b10;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_LS = 1'b1;

  // Illegal size or an address not aligned to the access size.
  function automatic logic access_bad(input logic [1:0] len, input logic [1:0] addr_lo);
    logic bad;
    case (len)
      LEN_B:   bad = 1'b0;
      LEN_H:   bad = addr_lo[0];
      LEN_W:   bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin grant; last_grant advances only when a grant is taken.
module mem_rr_arb2
  import mem_port_arbiter_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_req_if,
  input  logic i_req_ls,
  output logic o_gnt_if,
  output logic o_gnt_ls
);

  logic r_last;

  // Grant the single requester, or the one not granted last when both ask.
  always_comb begin
    o_gnt_if = 1'b0;
    o_gnt_ls = 1'b0;
    if (i_en) begin
      if (i_req_if && i_req_ls) begin
        o_gnt_if = (r_last == PORT_LS);
        o_gnt_ls = (r_last == PORT_IF);
      end else begin
        o_gnt_if = i_req_if;
        o_gnt_ls = i_req_ls;
      end
    end
  end

  // Remember who won; reset favours IF on the first contested cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last <= PORT_LS;
    end else if (o_gnt_if) begin
      r_last <= PORT_IF;
    end else if (o_gnt_ls) begin
      r_last <= PORT_LS;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises IF and LS requests onto one memory port, one transaction in flight.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_wen,
  input  logic [1:0]        if_len,
  input  logic [DATA_W-1:0] if_wdata,
  input  logic              ls_req_valid,
  output logic              ls_req_ready,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic              ls_wen,
  input  logic [1:0]        ls_len,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              if_resp_valid,
  output logic              ls_resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [1:0]        mem_len,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_rdata,
  output logic              busy,
  output logic              late_err
);

  // WAIT counter runs 0..TIMEOUT-1; the last value is the TIMEOUT-th cycle.
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_t        r_state;
  arb_state_t        w_next;
  logic              r_owner;
  logic [ADDR_W-1:0] r_addr;
  logic              r_wen;
  logic [1:0]        r_len;
  logic [DATA_W-1:0] r_wdata;
  logic [CNT_W-1:0]  r_cnt;

  logic              r_mem_req_valid;
  logic              r_busy;
  logic              r_if_resp_valid;
  logic              r_ls_resp_valid;
  logic [DATA_W-1:0] r_resp_rdata;
  logic              r_resp_err;
  logic              r_late_err;

  logic              w_idle;
  logic              w_gnt_if;
  logic              w_gnt_ls;
  logic              w_accept;
  logic              w_acc_owner;
  logic [ADDR_W-1:0] w_acc_addr;
  logic              w_acc_wen;
  logic [1:0]        w_acc_len;
  logic [DATA_W-1:0] w_acc_wdata;
  logic              w_acc_bad;
  logic              w_owner_next;
  logic [DATA_W-1:0] w_resp_rdata;
  logic              w_resp_err;

  assign w_idle = (r_state == ST_IDLE);

  mem_rr_arb2 u_arb (
    .i_clk    (clk),
    .i_rst_n  (rst),
    .i_en     (w_idle),
    .i_req_if (if_req_valid),
    .i_req_ls (ls_req_valid),
    .o_gnt_if (w_gnt_if),
    .o_gnt_ls (w_gnt_ls)
  );

  assign if_req_ready = w_gnt_if;
  assign ls_req_ready = w_gnt_ls;
  assign w_accept     = w_gnt_if | w_gnt_ls;
  assign w_acc_owner  = w_gnt_ls ? PORT_LS : PORT_IF;
  assign w_acc_addr   = w_gnt_ls ? ls_addr  : if_addr;
  assign w_acc_wen    = w_gnt_ls ? ls_wen   : if_wen;
  assign w_acc_len    = w_gnt_ls ? ls_len   : if_len;
  assign w_acc_wdata  = w_gnt_ls ? ls_wdata : if_wdata;
  assign w_acc_bad    = access_bad(w_acc_len, w_acc_addr[1:0]);
  assign w_owner_next = w_accept ? w_acc_owner : r_owner;

  // Next state plus the response payload to latch when entering RESP.
  always_comb begin
    w_next       = r_state;
    w_resp_rdata = '0;
    w_resp_err   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_acc_bad) begin
            w_next     = ST_RESP;
            w_resp_err = 1'b1;
          end else begin
            w_next = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (mem_req_ready) w_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_resp_valid) begin
          w_next       = ST_RESP;
          w_resp_rdata = r_wen ? '0 : mem_resp_rdata;
        end else if (r_cnt == CNT_LAST) begin
          w_next     = ST_RESP;
          w_resp_err = 1'b1;
        end
      end
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // State, captured request and WAIT counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_owner <= PORT_IF;
      r_addr  <= '0;
      r_wen   <= 1'b0;
      r_len   <= 2'b00;
      r_wdata <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_owner <= w_acc_owner;
        r_addr  <= w_acc_addr;
        r_wen   <= w_acc_wen;
        r_len   <= w_acc_len;
        r_wdata <= w_acc_wdata;
      end
      if (r_state == ST_WAIT) r_cnt <= r_cnt + 1'b1;
      else                    r_cnt <= '0;
    end
  end

  // Registered status and response outputs, decoded from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem_req_valid <= 1'b0;
      r_busy          <= 1'b0;
      r_if_resp_valid <= 1'b0;
      r_ls_resp_valid <= 1'b0;
      r_resp_rdata    <= '0;
      r_resp_err      <= 1'b0;
      r_late_err      <= 1'b0;
    end else begin
      r_mem_req_valid <= (w_next == ST_REQ);
      r_busy          <= (w_next != ST_IDLE);
      r_if_resp_valid <= (w_next == ST_RESP) && (w_owner_next == PORT_IF);
      r_ls_resp_valid <= (w_next == ST_RESP) && (w_owner_next == PORT_LS);
      r_resp_rdata    <= w_resp_rdata;
      r_resp_err      <= w_resp_err;
      if (mem_resp_valid && (r_state != ST_WAIT)) r_late_err <= 1'b1;
    end
  end

  assign mem_req_valid = r_mem_req_valid;
  assign mem_addr      = r_addr;
  assign mem_wen       = r_wen;
  assign mem_len       = r_len;
  assign mem_wdata     = r_wdata;
  assign busy          = r_busy;
  assign if_resp_valid = r_if_resp_valid;
  assign ls_resp_valid = r_ls_resp_valid;
  assign resp_rdata    = r_resp_rdata;
  assign resp_err      = r_resp_err;
  assign late_err      = r_late_err;

endmodule
